// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a one-entry skid buffer, flush, and
// control zeroing on bubbles. Optional saturating stall counter enabled by STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
`ifdef STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;

  logic              w_accept;
  logic              w_deliver;
  logic              w_main_valid_d;
  logic              w_skid_valid_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_skid_data_d;
  logic [CTRL_W-1:0] w_skid_ctrl_d;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_main_valid & out_ready;

  // Occupancy is encoded by the two valid bits: EMPTY, ONE (main), TWO (main + skid).
  always_comb begin
    w_main_valid_d = r_main_valid;
    w_skid_valid_d = r_skid_valid;
    w_main_data_d  = r_main_data;
    w_main_ctrl_d  = r_main_ctrl;
    w_skid_data_d  = r_skid_data;
    w_skid_ctrl_d  = r_skid_ctrl;
    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (r_skid_valid) begin
      if (w_deliver) begin
        w_main_data_d  = r_skid_data;
        w_main_ctrl_d  = r_skid_ctrl;
        w_skid_valid_d = 1'b0;
      end
    end else if (r_main_valid) begin
      if (w_accept && w_deliver) begin
        w_main_data_d = in_data;
        w_main_ctrl_d = in_ctrl;
      end else if (w_accept) begin
        w_skid_data_d  = in_data;
        w_skid_ctrl_d  = in_ctrl;
        w_skid_valid_d = 1'b1;
      end else if (w_deliver) begin
        w_main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      w_main_data_d  = in_data;
      w_main_ctrl_d  = in_ctrl;
      w_main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_skid_valid <= w_skid_valid_d;
      r_main_data  <= w_main_data_d;
      r_main_ctrl  <= w_main_ctrl_d;
      r_skid_data  <= w_skid_data_d;
      r_skid_ctrl  <= w_skid_ctrl_d;
      // Ready is the complement of the next skid state, so it never depends on out_ready.
      r_in_ready   <= ~w_skid_valid_d;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model plus a negedge monitor/scoreboard.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 4;
`ifdef STALL_CNT_EN
  localparam int CNTW = 4;
  logic [CNTW-1:0] stall_cnt;
  int              exp_stall = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  entry_t        exp_q[$];
  logic [DW-1:0] last_data = '0;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW)
`ifdef STALL_CNT_EN
    ,
    .CNT_W (CNTW)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 2 whose acceptance depends only on
  // the occupancy at the start of the cycle; flush empties it.
  always @(posedge clk or negedge rst_n) begin
    int n;
    bit acc;
    bit del;
    if (!rst_n) begin
      exp_q.delete();
`ifdef STALL_CNT_EN
      exp_stall <= 0;
`endif
    end else begin
      n   = exp_q.size();
      acc = in_valid && (n < 2);
      del = (n > 0) && out_ready;
`ifdef STALL_CNT_EN
      if (n > 0 && !out_ready && !flush && exp_stall < (1 << CNTW) - 1) exp_stall <= exp_stall + 1;
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        if (del) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({in_data, in_ctrl});
      end
    end
  end

  // Monitor: compares every presented output beat against the head of the expected queue.
  always @(negedge clk) begin
    int n;
    n = exp_q.size();
    check("in_ready", in_ready, n < 2);
    check("out_valid", out_valid, n > 0);
    if (n > 0) begin
      check("out_data", out_data, exp_q[0].d);
      check("out_ctrl", out_ctrl, exp_q[0].c);
    end else begin
      check("bubble_ctrl", out_ctrl, '0);
      check("hold_data", out_data, rst_n ? last_data : '0);
    end
    if (!rst_n) last_data <= '0;
    else if (n > 0) last_data <= exp_q[0].d;
`ifdef STALL_CNT_EN
    check("stall_cnt", stall_cnt, exp_stall);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    do begin
      acc = in_ready;
      step();
      guard++;
    end while (!acc && guard < 50);
    in_valid = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Reset in the middle of a transfer
    out_ready = 1'b0;
    send(32'h55, 4'h1);
    send(32'h66, 4'h2);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // One-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5;
    in_ctrl   = 4'h3;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", out_valid, 1'b1);
    check("lat_data", out_data, 32'hA5);
    check("lat_ctrl", out_ctrl, 4'h3);
    step();

    // Streaming
    for (int i = 1; i <= 8; i++) send(DW'(i), CW'(i));
    repeat (3) step();

    // Back-pressure
    out_ready = 1'b0;
    send(32'h10, 4'h1);
    send(32'h11, 4'h2);
    in_valid = 1'b1;
    in_data  = 32'h12;
    in_ctrl  = 4'h3;
    repeat (3) step();
    check("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    send(32'h12, 4'h3);
    repeat (4) step();

    // Flush while holding two entries, with a same-cycle input
    out_ready = 1'b0;
    send(32'h20, 4'h4);
    send(32'h21, 4'h5);
    in_valid = 1'b1;
    in_data  = 32'h22;
    in_ctrl  = 4'h6;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();

    // Control kill
    out_ready = 1'b0;
    send(32'h30, 4'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();

`ifdef STALL_CNT_EN
    out_ready = 1'b0;
    send(32'h40, 4'h1);
    repeat (20) step();
    check("stall_sat", stall_cnt, 4'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("stall_after_flush", stall_cnt, 4'hF);
    rst_n = 1'b0;
    #1;
    check("stall_after_rst", stall_cnt, 4'h0);
    step();
    rst_n = 1'b1;
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
